// File: rtl/draw_pkg.sv
// Shared drawing definitions: screen limits, palette, plotter FSM states and
// the 16x16 bitmaps used by the glyph ROM.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FINISH
  } plot_state_e;

  localparam int GLYPH_ROWS = 16;
  typedef logic [15:0] glyph_row_t;

  // Right-pointing arrow; MSB is the leftmost pixel of each row.
  localparam glyph_row_t ARROW_BITMAP [GLYPH_ROWS] = '{
    16'h0000, 16'h0100, 16'h0180, 16'h01C0,
    16'h01E0, 16'hFFF0, 16'hFFF8, 16'hFFFC,
    16'hFFFC, 16'hFFF8, 16'hFFF0, 16'h01E0,
    16'h01C0, 16'h0180, 16'h0100, 16'h0000
  };

  // Plus-shaped cross with 4-pixel-wide bars through the centre.
  localparam glyph_row_t CROSS_BITMAP [GLYPH_ROWS] = '{
    16'h03C0, 16'h03C0, 16'h03C0, 16'h03C0,
    16'h03C0, 16'h03C0, 16'hFFFF, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'h03C0, 16'h03C0,
    16'h03C0, 16'h03C0, 16'h03C0, 16'h03C0
  };

  function automatic glyph_row_t bitmap_row(input int sel, input int r);
    glyph_row_t w;
    w = '0;
    if (r >= 0 && r < GLYPH_ROWS) begin
      case (sel)
        2:       w = ARROW_BITMAP[r[3:0]];
        3:       w = CROSS_BITMAP[r[3:0]];
        default: w = '0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/glyph_plotter_rom.sv
// Combinational glyph ROM: (glyph_sel, row) -> GLYPH_W-bit row word, MSB leftmost.
// Glyph 0 solid, 1 empty, 2 arrow, 3 cross; out-of-range selections read as empty.
module glyph_rom
  import draw_pkg::*;
#(
  parameter int GLYPH_W    = 16,
  parameter int NUM_GLYPHS = 4,
  parameter int SEL_W      = 2,
  parameter int ROW_W      = 4
) (
  input  logic [SEL_W-1:0]   glyph_sel,
  input  logic [ROW_W-1:0]   row,
  output logic [GLYPH_W-1:0] row_word
);

  always_comb begin
    // NOTE: assigning a default before any branch keeps always_comb free of inferred latches.
    row_word = '0;
    if (int'(glyph_sel) < NUM_GLYPHS) begin
      case (int'(glyph_sel))
        0:       row_word = '1;
        2, 3:    row_word = GLYPH_W'(bitmap_row(int'(glyph_sel), int'(row)));
        default: row_word = '0;
      endcase
    end
  end

endmodule

// File: rtl/glyph_plotter.sv
// Glyph plotter: on start, scans a ROM glyph row-major and emits one VGA write per cycle.
// Optional screen clipping is enabled by defining GLYPH_PLOTTER_CLIP_EN.
module glyph_plotter
  import draw_pkg::*;
#(
  parameter int GLYPH_W    = 16,
  parameter int GLYPH_H    = 16,
  parameter int NUM_GLYPHS = 4,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  localparam int SEL_W     = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [SEL_W-1:0]    glyph_sel,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                erase,
  output logic [X_W-1:0]      xout,
  output logic [Y_W-1:0]      yout,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(GLYPH_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_H - 1);

  plot_state_e         state, state_next;
  logic [SEL_W-1:0]    sel_lat;
  logic [X_W-1:0]      x_lat;
  logic [Y_W-1:0]      y_lat;
  logic [COLOUR_W-1:0] colour_lat;
  logic                erase_lat;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [GLYPH_W-1:0]  row_word;
  logic                pix_bit;
  logic                on_screen;
  logic                last_pixel;
  logic [X_W-1:0]      x_pix;
  logic [Y_W-1:0]      y_pix;

  glyph_rom #(
    .GLYPH_W   (GLYPH_W),
    .NUM_GLYPHS(NUM_GLYPHS),
    .SEL_W     (SEL_W),
    .ROW_W     (ROW_W)
  ) u_rom (
    .glyph_sel(sel_lat),
    .row      (row),
    .row_word (row_word)
  );

  assign pix_bit    = row_word[LAST_COL - col];
  assign last_pixel = (col == LAST_COL) && (row == LAST_ROW);
  assign x_pix      = x_lat + X_W'(col);
  assign y_pix      = y_lat + Y_W'(row);

`ifdef GLYPH_PLOTTER_CLIP_EN
  // One bit wider so a sum past the coordinate range is still seen as off-screen.
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  assign sum_x     = {1'b0, x_lat} + (X_W + 1)'(col);
  assign sum_y     = {1'b0, y_lat} + (Y_W + 1)'(row);
  assign on_screen = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
`else
  assign on_screen = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last_pixel) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_lat    <= '0;
      x_lat      <= '0;
      y_lat      <= '0;
      colour_lat <= '0;
      erase_lat  <= 1'b0;
      col        <= '0;
      row        <= '0;
      xout       <= '0;
      yout       <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sel_lat    <= glyph_sel;
            x_lat      <= x;
            y_lat      <= y;
            colour_lat <= colour_in;
            erase_lat  <= erase;
            col        <= '0;
            row        <= '0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          xout   <= x_pix;
          yout   <= y_pix;
          colour <= erase_lat ? COLOUR_W'(BLACK) : colour_lat;
          plot   <= pix_bit & on_screen;
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_plotter.sv
// Self-checking bench for glyph_plotter: directed command table, multi-cycle
// handshake/reset sequences and random commands against a geometric glyph model.
module tb_glyph_plotter;

  localparam int GW = 16;
  localparam int GH = 16;
  localparam int NPIX = GW * GH;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] glyph_sel;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour_in;
  logic       erase;
  logic [7:0] xout;
  logic [6:0] yout;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  glyph_plotter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .glyph_sel(glyph_sel),
    .x        (x),
    .y        (y),
    .colour_in(colour_in),
    .erase    (erase),
    .xout     (xout),
    .yout     (yout),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Glyph shapes described geometrically rather than as bitmaps.
  function automatic bit model_pixel(input int sel, input int r, input int c,
                                     input int x0, input int y0);
    bit on;
    int d;
    d = (r < 15 - r) ? r : 15 - r;
    case (sel)
      0:       on = 1'b1;
      1:       on = 1'b0;
      2:       on = (r >= 1 && r <= 14 && c >= 7 && c < 7 + d) || (r >= 5 && r <= 10 && c <= 6);
      3:       on = (c >= 6 && c <= 9) || (r >= 6 && r <= 9);
      default: on = 1'b0;
    endcase
`ifdef GLYPH_PLOTTER_CLIP_EN
    if (x0 + c >= 160 || y0 + r >= 120) on = 1'b0;
`endif
    return on;
  endfunction

  task automatic drive_cmd(input int sel, input int x0, input int y0, input int c0, input bit er);
    glyph_sel = 2'(sel);
    x         = 8'(x0);
    y         = 7'(y0);
    colour_in = 3'(c0);
    erase     = er;
  endtask

  // Launch a command on the next rising edge; returns just after that edge.
  task automatic issue(input int sel, input int x0, input int y0, input int c0, input bit er);
    @(negedge clk);
    drive_cmd(sel, x0, y0, c0, er);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the accepting edge; ends at the sample point where done is high.
  task automatic scan_check(input string tag, input int sel, input int x0, input int y0,
                            input int c0, input bit er, output int n,
                            output int fx, output int fy, output int lx, output int ly);
    int  r, c;
    bit  exp_on;
    n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    @(negedge clk);
    check({tag, " busy after accept"}, busy, 1);
    check({tag, " no plot before first pixel"}, plot, 0);
    for (int i = 0; i < NPIX; i++) begin
      r = i / GW;
      c = i % GW;
      @(negedge clk);
      exp_on = model_pixel(sel, r, c, x0, y0);
      check($sformatf("%s plot px%0d", tag, i), plot, exp_on);
      check($sformatf("%s busy px%0d", tag, i), busy, 1);
      check($sformatf("%s done px%0d", tag, i), done, 0);
      if (plot === 1'b1) begin
        n++;
        check($sformatf("%s xout px%0d", tag, i), xout, (x0 + c) % 256);
        check($sformatf("%s yout px%0d", tag, i), yout, (y0 + r) % 128);
        check($sformatf("%s colour px%0d", tag, i), colour, er ? 0 : c0);
        if (fx < 0) begin fx = x0 + c; fy = y0 + r; end
        lx = (x0 + c) % 256;
        ly = (y0 + r) % 128;
        fx = fx % 256;
        fy = fy % 128;
      end
    end
    @(negedge clk);
    check({tag, " done pulse"}, done, 1);
    check({tag, " busy falls with done"}, busy, 0);
    check({tag, " no plot at done"}, plot, 0);
  endtask

  typedef struct {
    int sel, x0, y0, c0;
    bit er;
    int plots, fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, fx, fy, lx, ly, exp_n, seen;

    vecs[0] = '{0, 10, 20, 3, 1'b0, 256, 10, 20, 25, 35};
    vecs[1] = '{0, 10, 20, 3, 1'b1, 256, 10, 20, 25, 35};
    vecs[2] = '{1, 10, 20, 3, 1'b0,   0, -1, -1, -1, -1};
    vecs[3] = '{2, 40, 50, 5, 1'b0,  98, 47, 51, 47, 64};
    vecs[4] = '{3,  0,  0, 7, 1'b0, 112,  6,  0,  9, 15};
`ifdef GLYPH_PLOTTER_CLIP_EN
    vecs[5] = '{0, 150,   0, 2, 1'b0, 160, 150,   0, 159, 15};
    vecs[6] = '{0, 250, 115, 6, 1'b0,   0,  -1,  -1,  -1, -1};
`else
    vecs[5] = '{0, 150,   0, 2, 1'b0, 256, 150,   0, 165, 15};
    vecs[6] = '{0, 250, 115, 6, 1'b0, 256, 250, 115,   9,  2};
`endif

    reset_n = 1'b0;
    start   = 1'b0;
    drive_cmd(0, 0, 0, 0, 1'b0);
    #1;
    check("reset xout", xout, 0);
    check("reset yout", yout, 0);
    check("reset colour", colour, 0);
    check("reset plot", plot, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed command table.
    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].sel, vecs[v].x0, vecs[v].y0, vecs[v].c0, vecs[v].er);
      scan_check($sformatf("vec%0d", v), vecs[v].sel, vecs[v].x0, vecs[v].y0,
                 vecs[v].c0, vecs[v].er, n, fx, fy, lx, ly);
      check($sformatf("vec%0d plot count", v), n, vecs[v].plots);
      if (vecs[v].plots > 0) begin
        check($sformatf("vec%0d first x", v), fx, vecs[v].fx);
        check($sformatf("vec%0d first y", v), fy, vecs[v].fy);
        check($sformatf("vec%0d last x", v), lx, vecs[v].lx);
        check($sformatf("vec%0d last y", v), ly, vecs[v].ly);
      end
      @(negedge clk);
      check($sformatf("vec%0d done one cycle", v), done, 0);
      check($sformatf("vec%0d idle busy", v), busy, 0);
    end

    // Start held high: mid-command input changes are ignored, done-cycle start is taken.
    @(negedge clk);
    drive_cmd(0, 30, 40, 5, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 drive_cmd(0, 70, 60, 6, 1'b0);
    scan_check("held1", 0, 30, 40, 5, 1'b0, n, fx, fy, lx, ly);
    check("held1 plot count", n, 256);
    check("held1 first x", fx, 30);
    @(posedge clk);
    #1 start = 1'b0;
    scan_check("held2", 0, 70, 60, 6, 1'b0, n, fx, fy, lx, ly);
    check("held2 plot count", n, 256);
    check("held2 first x", fx, 70);
    check("held2 first y", fy, 60);
    @(negedge clk);

    // Start seen only in the FINISH cycle is ignored.
    issue(1, 0, 0, 1, 1'b0);
    repeat (NPIX + 1) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("finish-start done", done, 1);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("finish-start ignored busy", busy, 0);
      check("finish-start ignored plot", plot, 0);
    end

    // Asynchronous reset after the 100th plot.
    issue(0, 5, 5, 7, 1'b0);
    seen = 0;
    for (int cyc = 0; cyc < 300 && seen < 100; cyc++) begin
      @(negedge clk);
      if (plot === 1'b1) seen++;
    end
    check("reached 100 plots", seen, 100);
    reset_n = 1'b0;
    #1;
    check("midreset xout", xout, 0);
    check("midreset yout", yout, 0);
    check("midreset colour", colour, 0);
    check("midreset plot", plot, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen++;
    end
    check("post-reset quiet cycles with activity", seen, 0);
    issue(0, 5, 5, 7, 1'b0);
    scan_check("after reset", 0, 5, 5, 7, 1'b0, n, fx, fy, lx, ly);
    check("after reset plot count", n, 256);
    @(negedge clk);

    // Random commands against the model.
    for (int k = 0; k < 6; k++) begin
      int rs, rx, ry, rc;
      bit re;
      rs = int'($urandom_range(0, 3));
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 127));
      rc = int'($urandom_range(0, 7));
      re = 1'($urandom_range(0, 1));
      exp_n = 0;
      for (int i = 0; i < NPIX; i++)
        if (model_pixel(rs, i / GW, i % GW, rx, ry)) exp_n++;
      issue(rs, rx, ry, rc, re);
      scan_check($sformatf("rand%0d", k), rs, rx, ry, rc, re, n, fx, fy, lx, ly);
      check($sformatf("rand%0d plot count", k), n, exp_n);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
